// File: rtl/ofdm_symbol_scheduler_if.sv
// Scheduler-side bundle: producer request lanes, serializer handshake and status outputs.
// The master modport belongs to the scheduler and the slave modport to its environment.
interface ofdm_symbol_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 304
);
  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                      enable;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      ser_ready;
  logic                      ser_done;
  logic                      ser_valid;
  logic [DATA_W-1:0]         ser_data;
  logic [NUM_REQ-1:0]        grant;
  logic [IdW-1:0]            grant_id;
  logic                      busy;
  logic [15:0]               sym_count;
  logic                      err;

  modport master (
    input  enable,
    input  req_valid,
    input  req_data,
    input  ser_ready,
    input  ser_done,
    output req_ready,
    output ser_valid,
    output ser_data,
    output grant,
    output grant_id,
    output busy,
    output sym_count,
    output err
  );

  modport slave (
    output enable,
    output req_valid,
    output req_data,
    output ser_ready,
    output ser_done,
    input  req_ready,
    input  ser_valid,
    input  ser_data,
    input  grant,
    input  grant_id,
    input  busy,
    input  sym_count,
    input  err
  );
endinterface

// File: rtl/ofdm_symbol_scheduler.sv
// Round-robin owner selection with burst ownership in front of one shared 304-to-16 serializer.
// Dispatches one symbol at a time and waits for done, guarded by a sticky timeout watchdog.
module ofdm_symbol_scheduler #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 304,
  parameter int unsigned BURST_LEN = 1,
  parameter int unsigned TIMEOUT   = 64
) (
  input logic                     clk,
  input logic                     reset,
  ofdm_symbol_scheduler_if.master bus
);
  localparam int unsigned IdW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  localparam logic [IdW-1:0]  LastId   = IdW'(NUM_REQ - 1);
  localparam logic [3:0]      BurstMax = 4'(BURST_LEN);
  localparam logic [TmoW-1:0] TmoOne   = TmoW'(1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitDone} state_e;

  state_e                state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
  logic [IdW-1:0]        grant_id_q, grant_id_d;
  logic [3:0]            burst_cnt_q, burst_cnt_d;
  logic [TmoW-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                  ser_valid_q, ser_valid_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     ser_data_q, ser_data_d;
  logic [15:0]           sym_count_q, sym_count_d;

  logic                  keep_owner;
  logic                  rr_found;
  logic [IdW-1:0]        rr_idx;
  logic [IdW-1:0]        scan_idx;
  logic [IdW-1:0]        owner;
  int unsigned           scan_pos;

  // Scan starts just past the last owner and wraps, so the last owner is checked last.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = grant_id_q;
    scan_pos = 0;
    scan_idx = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      scan_pos = (32'(grant_id_q) + i) % NUM_REQ;
      scan_idx = IdW'(scan_pos);
      if (!rr_found && bus.req_valid[scan_idx]) begin
        rr_found = 1'b1;
        rr_idx   = scan_idx;
      end
    end
  end

  assign keep_owner = bus.req_valid[grant_id_q] && (burst_cnt_q < BurstMax);
  assign owner      = keep_owner ? grant_id_q : rr_idx;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    req_ready_d = req_ready_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    ser_valid_d = ser_valid_q;
    busy_d      = busy_q;
    err_d       = err_q;
    ser_data_d  = ser_data_q;
    sym_count_d = sym_count_q;

    unique case (state_q)
      StIdle: begin
        if (bus.enable && bus.ser_ready && (|bus.req_valid)) begin
          grant_id_d         = owner;
          burst_cnt_d        = keep_owner ? (burst_cnt_q + 4'd1) : 4'd1;
          grant_d            = '0;
          grant_d[owner]     = 1'b1;
          req_ready_d        = '0;
          req_ready_d[owner] = 1'b1;
          ser_valid_d        = 1'b1;
          ser_data_d         = bus.req_data[32'(owner) * DATA_W +: DATA_W];
          sym_count_d        = sym_count_q + 16'd1;
          busy_d             = 1'b1;
          state_d            = StIssue;
        end
      end

      StIssue: begin
        ser_valid_d = 1'b0;
        req_ready_d = '0;
        tmo_cnt_d   = '0;
        state_d     = StWaitDone;
      end

      StWaitDone: begin
        tmo_cnt_d = tmo_cnt_q + TmoOne;
        // done takes priority over a coincident timeout and leaves err untouched
        if (bus.ser_done) begin
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (tmo_cnt_q == TmoLast) begin
          err_d   = 1'b1;
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      req_ready_q <= '0;
      grant_id_q  <= LastId;
      burst_cnt_q <= BurstMax;
      tmo_cnt_q   <= '0;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      ser_data_q  <= '0;
      sym_count_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      req_ready_q <= req_ready_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      ser_valid_q <= ser_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      ser_data_q  <= ser_data_d;
      sym_count_q <= sym_count_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_data  = ser_data_q;
  assign bus.grant     = grant_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.busy      = busy_q;
  assign bus.sym_count = sym_count_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_ofdm_symbol_scheduler.sv
// Bench for ofdm_symbol_scheduler: two instances (burst 1 and burst 2) share all inputs;
// a vector table drives single dispatches, hand sequences cover spacing, enable, timeout, reset.
module tb_ofdm_symbol_scheduler;
  localparam int unsigned N   = 4;
  localparam int unsigned DW  = 304;
  localparam int unsigned TMO = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic            enable;
  logic            ser_ready;
  logic            ser_done;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;

  ofdm_symbol_scheduler_if #(.NUM_REQ(N), .DATA_W(DW)) bus_a ();
  ofdm_symbol_scheduler_if #(.NUM_REQ(N), .DATA_W(DW)) bus_b ();

  assign bus_a.enable    = enable;
  assign bus_a.ser_ready = ser_ready;
  assign bus_a.ser_done  = ser_done;
  assign bus_a.req_valid = req_valid;
  assign bus_a.req_data  = req_data;
  assign bus_b.enable    = enable;
  assign bus_b.ser_ready = ser_ready;
  assign bus_b.ser_done  = ser_done;
  assign bus_b.req_valid = req_valid;
  assign bus_b.req_data  = req_data;

  ofdm_symbol_scheduler #(
    .NUM_REQ(N), .DATA_W(DW), .BURST_LEN(1), .TIMEOUT(TMO)
  ) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a)
  );

  ofdm_symbol_scheduler #(
    .NUM_REQ(N), .DATA_W(DW), .BURST_LEN(2), .TIMEOUT(TMO)
  ) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b)
  );

  // Output view of whichever instance is under check
  logic          sel;
  logic          o_ser_valid;
  logic [DW-1:0] o_ser_data;
  logic [N-1:0]  o_req_ready;
  logic [N-1:0]  o_grant;
  logic [1:0]    o_grant_id;
  logic          o_busy;
  logic [15:0]   o_sym_count;
  logic          o_err;

  always_comb begin
    if (sel) begin
      o_ser_valid = bus_b.ser_valid;
      o_ser_data  = bus_b.ser_data;
      o_req_ready = bus_b.req_ready;
      o_grant     = bus_b.grant;
      o_grant_id  = bus_b.grant_id;
      o_busy      = bus_b.busy;
      o_sym_count = bus_b.sym_count;
      o_err       = bus_b.err;
    end else begin
      o_ser_valid = bus_a.ser_valid;
      o_ser_data  = bus_a.ser_data;
      o_req_ready = bus_a.req_ready;
      o_grant     = bus_a.grant;
      o_grant_id  = bus_a.grant_id;
      o_busy      = bus_a.busy;
      o_sym_count = bus_a.sym_count;
      o_err       = bus_a.err;
    end
  end

  typedef struct {
    logic         rst;
    logic         sel;
    logic [N-1:0] rv;
    logic [1:0]   own;
    logic [15:0]  cnt;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] sym(input int k);
    logic [15:0] s;
    s = 16'h0014 + 16'(k);
    return {19{s}};
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, ".ser_valid"}, DW'(o_ser_valid), DW'(0));
    chk({tag, ".ser_data"},  o_ser_data,       DW'(0));
    chk({tag, ".req_ready"}, DW'(o_req_ready), DW'(0));
    chk({tag, ".grant"},     DW'(o_grant),     DW'(0));
    chk({tag, ".grant_id"},  DW'(o_grant_id),  DW'(N - 1));
    chk({tag, ".busy"},      DW'(o_busy),      DW'(0));
    chk({tag, ".sym_count"}, DW'(o_sym_count), DW'(0));
    chk({tag, ".err"},       DW'(o_err),       DW'(0));
  endtask

  task automatic do_reset();
    req_valid = '0;
    enable    = 1'b1;
    ser_ready = 1'b1;
    ser_done  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset("rst");
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (o_ser_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_valid: got no ser_valid want a dispatch within 60 cycles");
    end
  endtask

  task automatic pulse_done();
    ser_done = 1'b1;
    @(negedge clk);
    ser_done = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit           ok;
    logic [N-1:0] one_hot;
    string        t;
    t = $sformatf("v%0d", idx);
    sel = v.sel;
    if (v.rst) do_reset();
    one_hot   = N'(1) << v.own;
    req_valid = v.rv;
    wait_valid(ok);
    if (ok) begin
      chk({t, ".grant"},     DW'(o_grant),     DW'(one_hot));
      chk({t, ".grant_id"},  DW'(o_grant_id),  DW'(v.own));
      chk({t, ".req_ready"}, DW'(o_req_ready), DW'(one_hot));
      chk({t, ".ser_data"},  o_ser_data,       sym(int'(v.own)));
      chk({t, ".sym_count"}, DW'(o_sym_count), DW'(v.cnt));
      chk({t, ".busy"},      DW'(o_busy),      DW'(1));
      // producer advances after its accept pulse; ser_data must not follow
      req_valid = '0;
      req_data[32'(v.own) * DW +: DW] = ~sym(int'(v.own));
      @(negedge clk);
      chk({t, ".valid_pulse"}, DW'(o_ser_valid), DW'(0));
      chk({t, ".ready_pulse"}, DW'(o_req_ready), DW'(0));
      repeat (18) @(negedge clk);
      pulse_done();
      req_data[32'(v.own) * DW +: DW] = sym(int'(v.own));
      @(negedge clk);
      chk({t, ".idle_busy"},  DW'(o_busy),  DW'(0));
      chk({t, ".idle_grant"}, DW'(o_grant), DW'(0));
      chk({t, ".held_data"},  o_ser_data,   sym(int'(v.own)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int nval;
    int cyc;

    // {rst, sel, req_valid, expected owner, expected sym_count}
    vq.push_back('{1'b1, 1'b0, 4'b0001, 2'd0, 16'd1});
    vq.push_back('{1'b1, 1'b0, 4'b1111, 2'd0, 16'd1});
    vq.push_back('{1'b0, 1'b0, 4'b1111, 2'd1, 16'd2});
    vq.push_back('{1'b0, 1'b0, 4'b1111, 2'd2, 16'd3});
    vq.push_back('{1'b0, 1'b0, 4'b1111, 2'd3, 16'd4});
    vq.push_back('{1'b0, 1'b0, 4'b1111, 2'd0, 16'd5});
    vq.push_back('{1'b0, 1'b0, 4'b0101, 2'd2, 16'd6});
    vq.push_back('{1'b0, 1'b0, 4'b0101, 2'd0, 16'd7});
    vq.push_back('{1'b0, 1'b0, 4'b1000, 2'd3, 16'd8});
    vq.push_back('{1'b0, 1'b0, 4'b0110, 2'd1, 16'd9});
    vq.push_back('{1'b0, 1'b0, 4'b0010, 2'd1, 16'd10});
    vq.push_back('{1'b1, 1'b1, 4'b1111, 2'd0, 16'd1});
    vq.push_back('{1'b0, 1'b1, 4'b1111, 2'd0, 16'd2});
    vq.push_back('{1'b0, 1'b1, 4'b1111, 2'd1, 16'd3});
    vq.push_back('{1'b0, 1'b1, 4'b1111, 2'd1, 16'd4});
    vq.push_back('{1'b0, 1'b1, 4'b1111, 2'd2, 16'd5});
    vq.push_back('{1'b0, 1'b1, 4'b1111, 2'd2, 16'd6});
    vq.push_back('{1'b1, 1'b1, 4'b1111, 2'd0, 16'd1});
    vq.push_back('{1'b0, 1'b1, 4'b1111, 2'd0, 16'd2});
    vq.push_back('{1'b0, 1'b1, 4'b1111, 2'd1, 16'd3});
    vq.push_back('{1'b0, 1'b1, 4'b1101, 2'd2, 16'd4});
    vq.push_back('{1'b0, 1'b1, 4'b1101, 2'd2, 16'd5});
    vq.push_back('{1'b0, 1'b1, 4'b1101, 2'd3, 16'd6});
    vq.push_back('{1'b0, 1'b1, 4'b0001, 2'd0, 16'd7});

    sel       = 1'b0;
    enable    = 1'b1;
    ser_ready = 1'b1;
    ser_done  = 1'b0;
    req_valid = '0;
    for (int k = 0; k < int'(N); k++) req_data[k * DW +: DW] = sym(k);

    for (int i = 0; i < vq.size(); i++) run_vec(vq[i], i);

    // Done-to-next-dispatch spacing with the requester held valid
    sel = 1'b0;
    do_reset();
    req_valid = 4'b0001;
    wait_valid(ok);
    chk("gap.first_id", DW'(o_grant_id), DW'(0));
    repeat (18) @(negedge clk);
    pulse_done();
    chk("gap.no_valid", DW'(o_ser_valid), DW'(0));
    @(negedge clk);
    chk("gap.valid", DW'(o_ser_valid), DW'(1));
    chk("gap.id",    DW'(o_grant_id),  DW'(0));
    chk("gap.count", DW'(o_sym_count), DW'(2));

    // enable dropped mid-flight: symbol completes, nothing new starts
    req_valid = '0;
    @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    pulse_done();
    req_valid = 4'b1111;
    nval = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_ser_valid) nval++;
    end
    ser_ready = 1'b0;
    enable    = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (o_ser_valid) nval++;
    end
    chk("en.no_dispatch", DW'(nval),        DW'(0));
    chk("en.idle",        DW'(o_busy),      DW'(0));
    chk("en.count",       DW'(o_sym_count), DW'(2));
    ser_ready = 1'b1;
    wait_valid(ok);
    chk("en.resume_id", DW'(o_grant_id),  DW'(1));
    chk("en.count3",    DW'(o_sym_count), DW'(3));

    // No done: watchdog fires after TMO cycles in WAIT_DONE
    req_valid = '0;
    cyc = 0;
    while (!o_err && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("tmo.cycles", DW'(cyc),     DW'(TMO + 1));
    chk("tmo.busy",   DW'(o_busy),  DW'(0));
    chk("tmo.grant",  DW'(o_grant), DW'(0));

    // err stays set across a new dispatch; async reset mid-WAIT_DONE clears everything
    req_valid = 4'b0001;
    wait_valid(ok);
    chk("sticky.err",   DW'(o_err),       DW'(1));
    chk("sticky.id",    DW'(o_grant_id),  DW'(0));
    chk("sticky.count", DW'(o_sym_count), DW'(4));
    req_valid = '0;
    repeat (5) @(negedge clk);
    chk("mid.busy", DW'(o_busy), DW'(1));
    #2 reset = 1'b0;
    #1 chk_reset("async");
    @(negedge clk);
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
